// File: rtl/tri_pin_serializer.sv
// Framed serial transmitter driving the O/T pair of a tristate pad buffer.
// Each word goes out as start bit, LSB-first payload, stop bit, then optional high-Z turnaround.
module tri_pin_serializer #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_W     = 8,
    parameter int TURNAROUND = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              pin_o,
    output logic              pin_t,
    output logic              busy,
    output logic              frame_done
);

    localparam int BIT_MAX = (DATA_W > TURNAROUND) ? DATA_W : TURNAROUND;
    localparam int DIV_W   = $clog2(CLK_DIV) + 1;
    localparam int BIT_W   = $clog2(BIT_MAX) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] TURN_LAST = BIT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, TURN} state_t;

    state_t            state, state_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic              period_end, accept;
    logic              pin_o_next, pin_t_next, busy_next, done_next;

    assign in_ready   = (state == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign period_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = START;
            START: if (period_end) state_next = DATA;
            DATA:  if (period_end && bit_cnt == DATA_LAST) state_next = STOP;
            STOP:  if (period_end) state_next = (TURNAROUND > 0) ? TURN : IDLE;
            TURN:  if (period_end && bit_cnt == TURN_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counters only run inside a frame and restart at every phase change.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE || state != state_next) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (period_end) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        shreg_next = shreg;
        if (accept)
            shreg_next = in_data;
        else if (state == DATA && period_end)
            shreg_next = shreg >> 1;
    end

    // Pin values are precomputed from the next state so the pad sees registered, glitch-free levels.
    always_comb begin
        pin_t_next = 1'b1;
        pin_o_next = 1'b0;
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == IDLE) && (state == STOP || state == TURN);
        case (state_next)
            START: pin_t_next = 1'b0;
            DATA: begin
                pin_t_next = 1'b0;
                pin_o_next = shreg_next[0];
            end
            STOP: begin
                pin_t_next = 1'b0;
                pin_o_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            pin_t      <= 1'b1;
            pin_o      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            shreg      <= shreg_next;
            pin_t      <= pin_t_next;
            pin_o      <= pin_o_next;
            busy       <= busy_next;
            frame_done <= done_next;
        end
    end

endmodule

// File: tb/tb_tri_pin_serializer.sv
// Bench for tri_pin_serializer: a 2/8/2 instance driven from a frame table with a pin-level
// scoreboard, plus a 1/1/0 instance for the degenerate-parameter frame.
module tb_tri_pin_serializer;

    localparam int CLK_DIV = 2;
    localparam int TURN    = 2;
    localparam int FRAME   = (8 + 2 + TURN) * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, pin_o, pin_t, busy, frame_done;

    logic [0:0] e_data = 1'b0;
    logic       e_valid = 1'b0;
    logic       e_ready, e_pin_o, e_pin_t, e_busy, e_done;

    tri_pin_serializer #(.CLK_DIV(CLK_DIV), .DATA_W(8), .TURNAROUND(TURN)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .pin_o(pin_o), .pin_t(pin_t), .busy(busy), .frame_done(frame_done)
    );

    tri_pin_serializer #(.CLK_DIV(1), .DATA_W(1), .TURNAROUND(0)) dut_edge (
        .clk(clk), .rst(rst), .in_data(e_data), .in_valid(e_valid), .in_ready(e_ready),
        .pin_o(e_pin_o), .pin_t(e_pin_t), .busy(e_busy), .frame_done(e_done)
    );

    typedef struct packed {logic t; logic o;} pin_exp_t;
    pin_exp_t sbq[$];

    // Frame bits are written out by hand in transmit order: start, LSB..MSB, stop.
    typedef struct {
        logic [7:0] data;
        logic [7:0] post;
        logic       keep;
        logic [0:9] bits;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int prev_accept = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a word, pushes its expected pin waveform at acceptance, then pops one entry per cycle.
    task automatic applyStimulus(input vec_t v);
        pin_exp_t e;
        in_data  = v.data;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !in_ready; i++) tick();
        checkOutput("accept_ready", in_ready, 1'b1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        prev_accept = accept_cyc;
        accept_cyc  = cyc;
        for (int k = 0; k < 10; k++)
            for (int c = 0; c < CLK_DIV; c++) sbq.push_back('{t: 1'b0, o: v.bits[k]});
        for (int c = 0; c < TURN * CLK_DIV; c++) sbq.push_back('{t: 1'b1, o: 1'b0});
        tick();
        in_data  = v.post;
        in_valid = v.keep;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("pin_t", pin_t, e.t);
            checkOutput("pin_o", pin_o, e.o);
            checkOutput("busy_in_frame", busy, 1'b1);
            checkOutput("no_early_done", frame_done, 1'b0);
            tick();
        end
        checkOutput("frame_done", frame_done, 1'b1);
        checkOutput("ready_after", in_ready, 1'b1);
        checkOutput("pin_t_released", pin_t, 1'b1);
        checkOutput("busy_after", busy, 1'b0);
    endtask

    vec_t vecs[5];
    vec_t v5a;
    logic seen_done;

    initial begin
        vecs[0] = '{data: 8'hA5, post: 8'hA5, keep: 1'b0, bits: 10'b0101001011};
        vecs[1] = '{data: 8'h00, post: 8'hFF, keep: 1'b1, bits: 10'b0000000001};
        vecs[2] = '{data: 8'hFF, post: 8'hFF, keep: 1'b0, bits: 10'b0111111111};
        vecs[3] = '{data: 8'h3C, post: 8'hC3, keep: 1'b0, bits: 10'b0001111001};
        vecs[4] = '{data: 8'h80, post: 8'h00, keep: 1'b0, bits: 10'b0000000011};
        v5a     = '{data: 8'h5A, post: 8'h00, keep: 1'b0, bits: 10'b0010110101};

        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst_pin_t", pin_t, 1'b1);
            checkOutput("rst_pin_o", pin_o, 1'b0);
            checkOutput("rst_ready", in_ready, 1'b0);
            checkOutput("rst_busy", busy, 1'b0);
            checkOutput("rst_done", frame_done, 1'b0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("ready_after_rst", in_ready, 1'b1);
        tick();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            if (i > 0 && vecs[i-1].keep) begin
                vectors++;
                if (accept_cyc - prev_accept != FRAME + 1) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_spacing: got %0d, expected %0d",
                             accept_cyc - prev_accept, FRAME + 1);
                end
            end
        end

        // Abort a frame during its fourth data bit.
        in_data  = 8'h3C;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !in_ready; i++) tick();
        checkOutput("abort_accept", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checkOutput("abort_bit3_t", pin_t, 1'b0);
        checkOutput("abort_bit3_o", pin_o, 1'b1);
        rst = 1'b1;
        tick();
        checkOutput("abort_pin_t", pin_t, 1'b1);
        checkOutput("abort_pin_o", pin_o, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", frame_done, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("abort_ready", in_ready, 1'b1);
        seen_done = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) begin
            seen_done |= frame_done;
            tick();
        end
        checkOutput("abort_no_done", seen_done, 1'b0);
        applyStimulus(v5a);

        // Degenerate parameters: one cycle per bit, one payload bit, no turnaround.
        in_valid = 1'b0;
        e_data   = 1'b1;
        e_valid  = 1'b1;
        for (int i = 0; i < 20 && !e_ready; i++) tick();
        checkOutput("edge_accept", e_ready, 1'b1);
        tick();
        e_valid = 1'b0;
        checkOutput("edge_start_t", e_pin_t, 1'b0);
        checkOutput("edge_start_o", e_pin_o, 1'b0);
        tick();
        checkOutput("edge_data_t", e_pin_t, 1'b0);
        checkOutput("edge_data_o", e_pin_o, 1'b1);
        tick();
        checkOutput("edge_stop_t", e_pin_t, 1'b0);
        checkOutput("edge_stop_o", e_pin_o, 1'b1);
        checkOutput("edge_busy", e_busy, 1'b1);
        tick();
        checkOutput("edge_release", e_pin_t, 1'b1);
        checkOutput("edge_done", e_done, 1'b1);
        checkOutput("edge_ready", e_ready, 1'b1);
        tick();
        checkOutput("edge_done_pulse", e_done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
